// File: rtl/sensor_scan_ctrl.sv
// ============================================================================
// Module   : sensor_scan_ctrl
// Brief    : Scans NUM_CH channels of a shared sensor input into shadow regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sensor_scan_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DW         = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    address,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic          read,
  output logic [31:0]   readdata,
  input  logic [DW-1:0] sample_in,
  output logic [2:0]    ch_sel,
  output logic          busy,
  output logic          irq
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_SELECT  = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  localparam logic [2:0] C_LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [3:0] C_SETTLE_INIT = 4'(SETTLE_CYC - 1);

  logic [2:0]        r_state;
  logic [2:0]        r_ch;
  logic [2:0]        r_ch_sel;
  logic [15:0]       r_pcnt;
  logic [3:0]        r_scnt;
  logic              r_enable;
  logic              r_irq_en;
  logic [15:0]       r_period;
  logic [NUM_CH-1:0] r_ready;
  logic [NUM_CH-1:0] r_overrun;
  logic              r_scan_done;
  logic [DW-1:0]     r_data [NUM_CH];
  logic [31:0]       r_readdata;
  logic              r_irq;

  logic              w_ctrl_wr;
  logic              w_period_wr;
  logic              w_status_wr;
  logic              w_capture;
  logic [NUM_CH-1:0] w_rdclr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_ctrl_wr   = write && (address == 4'd0);
  assign w_period_wr = write && (address == 4'd1);
  assign w_status_wr = write && (address == 4'd2);
  // An abort must never capture the in-flight channel.
  assign w_capture   = (r_state == S_CAPTURE) && r_enable;
  assign w_unused    = ^writedata[31:17];

  always_comb begin
    w_rdclr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rdclr[i] = read && (address == 4'(4 + i));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      4'd0: w_rdata = {30'd0, r_irq_en, r_enable};
      4'd1: w_rdata = {16'd0, r_period};
      4'd2: begin
        w_rdata[NUM_CH-1:0]  = r_ready;
        w_rdata[8 +: NUM_CH] = r_overrun;
        w_rdata[16]          = r_scan_done;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == 4'(4 + i)) w_rdata[DW-1:0] = r_data[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_period   <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= writedata[0];
        r_irq_en <= writedata[1];
      end
      if (w_period_wr) r_period <= writedata[15:0];
      r_readdata <= w_rdata;
      r_irq      <= r_irq_en & r_scan_done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_ch_sel <= '0;
      r_pcnt   <= '0;
      r_scnt   <= '0;
    end else if (!r_enable) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_ch_sel <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pcnt  <= r_period;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_pcnt == 16'd0) begin
            r_ch    <= '0;
            r_state <= S_SELECT;
          end else begin
            r_pcnt <= r_pcnt - 16'd1;
          end
        end
        S_SELECT: begin
          r_ch_sel <= r_ch;
          r_scnt   <= C_SETTLE_INIT;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_scnt == 4'd0) r_state <= S_CAPTURE;
          else                r_scnt  <= r_scnt - 4'd1;
        end
        S_CAPTURE: begin
          if (r_ch == C_LAST_CH) begin
            r_pcnt  <= r_period;
            r_state <= S_WAIT;
          end else begin
            r_ch    <= r_ch + 3'd1;
            r_state <= S_SELECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clears are applied first so a same-cycle capture set always wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= '0;
      r_overrun   <= '0;
      r_scan_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_status_wr && writedata[i]) || w_rdclr[i]) r_ready[i] <= 1'b0;
        if (w_status_wr && writedata[8 + i]) r_overrun[i] <= 1'b0;
        if (w_capture && (r_ch == 3'(i))) begin
          r_data[i]  <= sample_in;
          r_ready[i] <= 1'b1;
          if (r_ready[i]) r_overrun[i] <= 1'b1;
        end
      end
      if (w_status_wr && writedata[16]) r_scan_done <= 1'b0;
      if (w_capture && (r_ch == C_LAST_CH)) r_scan_done <= 1'b1;
    end
  end

  assign readdata = r_readdata;
  assign ch_sel   = r_ch_sel;
  assign busy     = (r_state == S_SELECT) || (r_state == S_SETTLE) ||
                    (r_state == S_CAPTURE);
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_sensor_scan_ctrl.sv
// ============================================================================
// Module   : tb_sensor_scan_ctrl
// Brief    : Directed self-checking bench for sensor_scan_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sensor_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [15:0] sample_in;
  logic [2:0]  ch_sel;
  logic        busy;
  logic        irq;

  logic [15:0] r_base = 16'h1000;
  logic [31:0] d;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          hi_cnt;
  int          lo_cnt;

  assign sample_in = r_base + {13'd0, ch_sel};

  always #5 clk = ~clk;

  sensor_scan_ctrl #(.NUM_CH(4), .DW(16), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .sample_in (sample_in),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
    address = a; writedata = wd; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic rd, output logic [31:0] rdv);
    address = a; read = rd;
    @(posedge clk); #1;
    rdv = readdata; read = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy !== lvl && n < budget);
    chk("wait_busy", {31'd0, busy}, {31'd0, lvl});
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_ch_sel", {29'd0, ch_sel}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    #20 reset_n = 1'b1;
    tick(1);

    // Basic scan, PERIOD=0
    bus_write(4'd0, 32'h1);
    wait_busy(1'b1, 20);
    hi_cnt = 1;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      if (c % 4 == 1) chk($sformatf("ch_sel_c%0d", c), {29'd0, ch_sel}, 32'((c - 1) / 4));
      if (c < 16 && busy) hi_cnt++;
    end
    chk("busy_after_scan", {31'd0, busy}, 32'h0);
    chk("busy_len", 32'(hi_cnt), 32'd16);
    bus_write(4'd0, 32'h0);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(4 + i), 1'b0, d);
      chk($sformatf("ch_data%0d", i), d, 32'h1000 + 32'(i));
    end
    bus_read(4'd2, 1'b0, d);
    chk("status_scan1", d, 32'h1000F);

    // Second scan without reading -> overrun; then read-clear and W1C
    bus_write(4'd0, 32'h1);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 30);
    bus_write(4'd0, 32'h0);
    tick(2);
    bus_read(4'd2, 1'b0, d);
    chk("status_overrun", d, 32'h10F0F);
    bus_read(4'd6, 1'b1, d);
    chk("ch_data2_rdclr", d, 32'h1002);
    bus_read(4'd2, 1'b0, d);
    chk("status_ready2_clr", d, 32'h10F0B);
    bus_write(4'd2, 32'h00F00);
    bus_read(4'd2, 1'b0, d);
    chk("status_ovr_w1c", d, 32'h1000B);
    bus_write(4'd2, 32'h1FFFF);
    bus_read(4'd2, 1'b0, d);
    chk("status_all_w1c", d, 32'h0);

    // PERIOD=10: 11 idle cycles between scans
    bus_write(4'd1, 32'd10);
    bus_read(4'd1, 1'b0, d);
    chk("period_rd", d, 32'd10);
    bus_write(4'd0, 32'h1);
    wait_busy(1'b1, 40);
    for (int s = 0; s < 2; s++) begin
      hi_cnt = 1;
      lo_cnt = 0;
      while (busy && hi_cnt < 40) begin tick(1); if (busy) hi_cnt++; end
      while (!busy && lo_cnt < 40) begin lo_cnt++; tick(1); end
      chk($sformatf("period_busy_len%0d", s), 32'(hi_cnt), 32'd16);
      chk($sformatf("period_gap%0d", s), 32'(lo_cnt), 32'd11);
    end
    bus_write(4'd0, 32'h0);
    bus_write(4'd1, 32'd0);
    bus_write(4'd2, 32'h1FFFF);

    // Interrupt
    bus_write(4'd0, 32'h3);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 30);
    chk("irq_not_yet", {31'd0, irq}, 32'h0);
    tick(1);
    chk("irq_rise", {31'd0, irq}, 32'h1);
    bus_write(4'd2, 32'h10000);
    chk("irq_hold", {31'd0, irq}, 32'h1);
    tick(1);
    chk("irq_fall", {31'd0, irq}, 32'h0);
    // W1C of scan_done on the same edge that sets it
    wait_busy(1'b0, 30);
    wait_busy(1'b1, 5);
    tick(15);
    bus_write(4'd2, 32'h10000);
    chk("collide_align", {31'd0, busy}, 32'h0);
    bus_read(4'd2, 1'b0, d);
    chk("collide_scan_done", {31'd0, d[16]}, 32'h1);
    bus_write(4'd0, 32'h0);
    bus_write(4'd2, 32'h1FFFF);

    // Abort during SETTLE of ch1
    r_base = 16'h2000;
    bus_write(4'd0, 32'h1);
    wait_busy(1'b1, 20);
    tick(5);
    bus_write(4'd0, 32'h0);
    tick(1);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_ch_sel", {29'd0, ch_sel}, 32'h0);
    bus_read(4'd4, 1'b0, d);
    chk("abort_ch0", d, 32'h2000);
    bus_read(4'd5, 1'b0, d);
    chk("abort_ch1_kept", d, 32'h1001);
    bus_read(4'd2, 1'b0, d);
    chk("abort_status", d, 32'h1);
    r_base = 16'h3000;
    bus_write(4'd0, 32'h1);
    wait_busy(1'b1, 20);
    tick(4);
    bus_write(4'd0, 32'h0);
    tick(1);
    bus_read(4'd4, 1'b0, d);
    chk("restart_ch0", d, 32'h3000);
    bus_read(4'd5, 1'b0, d);
    chk("restart_ch1_kept", d, 32'h1001);

    // Asynchronous reset mid-scan
    r_base = 16'h1000;
    bus_write(4'd0, 32'h3);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 30);
    wait_busy(1'b1, 5);
    tick(5);
    address = 4'd2;
    tick(1);
    chk("pre_rst_ch_sel", {29'd0, ch_sel}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'h0);
    chk("async_rst_ch_sel", {29'd0, ch_sel}, 32'h0);
    chk("async_rst_busy", {31'd0, busy}, 32'h0);
    chk("async_rst_irq", {31'd0, irq}, 32'h0);
    #10 reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      bus_read(4'(a), 1'b0, d);
      chk($sformatf("post_rst_reg%0d", a), d, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
